// File: rtl/cond_unit.sv
// Condition unit: ARM condition evaluation, latched CondExR, write gating, a delayed
// per-group NZCV register and optional IT predication (enabled by defining COND_IT_EN).
module cond_unit #(
  parameter int FLAG_DELAY   = 1,
  parameter int FLAGW_GROUPS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              Cond,
  input  logic [3:0]              ALUFlags,
  input  logic [FLAGW_GROUPS-1:0] FlagW,
  input  logic                    PCS,
  input  logic                    NextPC,
  input  logic                    RegW,
  input  logic                    MemW,
  input  logic                    CondSample,
  input  logic                    InstrDone,
  input  logic                    ITStart,
  input  logic [3:0]              ITCond,
  input  logic [1:0]              ITLen,
  input  logic [3:0]              ITMask,
  output logic                    PCWrite,
  output logic                    RegWrite,
  output logic                    MemWrite,
  output logic [3:0]              Flags,
  output logic                    CondExR,
  output logic                    ITActive
);

  logic [3:0]              eff_cond;
  logic                    cond_ex;
  logic [FLAGW_GROUPS-1:0] flag_req;
  logic [FLAGW_GROUPS-1:0] group_en;
  logic [3:0]              flag_en;

`ifdef COND_IT_EN
  logic [2:0] it_count;
  logic [3:0] it_mask;

  // ITStart takes priority: a coincident InstrDone is the IT instruction retiring itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      it_count <= 3'd0;
      it_mask  <= 4'd0;
    end else if (ITStart) begin
      it_count <= {1'b0, ITLen} + 3'd1;
      it_mask  <= ITMask;
    end else if (InstrDone && ITActive) begin
      it_count <= it_count - 3'd1;
      it_mask  <= {1'b0, it_mask[3:1]};
    end
  end

  assign ITActive = (it_count != 3'd0);
  // An else slot flips bit 0, which inverts every condition (AL becomes NV).
  assign eff_cond = ITActive ? {ITCond[3:1], ITCond[0] ^ ~it_mask[0]} : Cond;
`else
  logic unused_it;
  assign unused_it = ^{ITStart, ITCond, ITLen, ITMask, InstrDone};
  assign ITActive  = 1'b0;
  assign eff_cond  = Cond;
`endif

  // NOTE: every variable gets a default before the case so no latch can be inferred.
  always_comb begin
    cond_ex = 1'b0;
    case (eff_cond)
      4'b0000: cond_ex = Flags[2];
      4'b0001: cond_ex = ~Flags[2];
      4'b0010: cond_ex = Flags[1];
      4'b0011: cond_ex = ~Flags[1];
      4'b0100: cond_ex = Flags[3];
      4'b0101: cond_ex = ~Flags[3];
      4'b0110: cond_ex = Flags[0];
      4'b0111: cond_ex = ~Flags[0];
      4'b1000: cond_ex = Flags[1] & ~Flags[2];
      4'b1001: cond_ex = ~(Flags[1] & ~Flags[2]);
      4'b1010: cond_ex = (Flags[3] == Flags[0]);
      4'b1011: cond_ex = (Flags[3] != Flags[0]);
      4'b1100: cond_ex = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: cond_ex = ~(~Flags[2] & (Flags[3] == Flags[0]));
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)           CondExR <= 1'b0;
    else if (CondSample) CondExR <= cond_ex;
  end

  assign flag_req = CondSample ? (FlagW & {FLAGW_GROUPS{cond_ex}}) : '0;

  generate
    if (FLAG_DELAY == 0) begin : g_no_delay
      assign group_en = flag_req;
    end else begin : g_delay
      logic [FLAGW_GROUPS-1:0] dly [FLAG_DELAY];
      // NOTE: the delay line is reset because its stages act directly as write enables.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < FLAG_DELAY; i++) dly[i] <= '0;
        end else begin
          dly[0] <= flag_req;
          for (int i = 1; i < FLAG_DELAY; i++) dly[i] <= dly[i-1];
        end
      end
      assign group_en = dly[FLAG_DELAY-1];
    end

    if (FLAGW_GROUPS == 4) begin : g_per_flag
      assign flag_en = group_en;
    end else begin : g_nz_cv
      assign flag_en = {group_en[1], group_en[1], group_en[0], group_en[0]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      Flags <= 4'd0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (flag_en[i]) Flags[i] <= ALUFlags[i];
    end
  end

  assign RegWrite = RegW & CondExR;
  assign MemWrite = MemW & CondExR;
  assign PCWrite  = (PCS & CondExR) | NextPC;

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit: condition table plus flag-delay,
// flag-group, reset and (with COND_IT_EN) predication sequences.
module tb_cond_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, CondSample, InstrDone, ITStart, PCS, NextPC, RegW, MemW;
  logic [3:0] Cond, ALUFlags, ITCond, ITMask, FlagW4;
  logic [1:0] ITLen, FlagW;

  logic       a_pcw, a_rw, a_mw, a_cer, a_ita;
  logic [3:0] a_flags, b_flags, c_flags;
  logic       b_unused_pcw, b_unused_rw, b_unused_mw, b_unused_cer, b_unused_ita;
  logic       c_unused_pcw, c_unused_rw, c_unused_mw, c_unused_cer, c_unused_ita;

  cond_unit #(.FLAG_DELAY(1), .FLAGW_GROUPS(2)) dut_a (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondSample(CondSample),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITMask(ITMask),
    .PCWrite(a_pcw), .RegWrite(a_rw), .MemWrite(a_mw), .Flags(a_flags), .CondExR(a_cer),
    .ITActive(a_ita));

  cond_unit #(.FLAG_DELAY(2), .FLAGW_GROUPS(4)) dut_b (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW4),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondSample(CondSample),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITMask(ITMask),
    .PCWrite(b_unused_pcw), .RegWrite(b_unused_rw), .MemWrite(b_unused_mw), .Flags(b_flags),
    .CondExR(b_unused_cer), .ITActive(b_unused_ita));

  cond_unit #(.FLAG_DELAY(0), .FLAGW_GROUPS(2)) dut_c (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .CondSample(CondSample),
    .InstrDone(InstrDone), .ITStart(ITStart), .ITCond(ITCond), .ITLen(ITLen), .ITMask(ITMask),
    .PCWrite(c_unused_pcw), .RegWrite(c_unused_rw), .MemWrite(c_unused_mw), .Flags(c_flags),
    .CondExR(c_unused_cer), .ITActive(c_unused_ita));

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;

  vec_t vecs [19];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] prev;
    logic       it_exp [3];

    //             NZCV     cond     result
    vecs[0]  = '{4'b0100, 4'b0000, 1'b1};  // EQ, Z=1
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};  // EQ, Z=0
    vecs[2]  = '{4'b0000, 4'b0001, 1'b1};  // NE
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};  // CS
    vecs[4]  = '{4'b0010, 4'b0011, 1'b0};  // CC
    vecs[5]  = '{4'b1000, 4'b0100, 1'b1};  // MI
    vecs[6]  = '{4'b1000, 4'b0101, 1'b0};  // PL
    vecs[7]  = '{4'b0001, 4'b0110, 1'b1};  // VS
    vecs[8]  = '{4'b0001, 4'b0111, 1'b0};  // VC
    vecs[9]  = '{4'b0010, 4'b1000, 1'b1};  // HI, C=1 Z=0
    vecs[10] = '{4'b0110, 4'b1000, 1'b0};  // HI, Z=1
    vecs[11] = '{4'b0110, 4'b1001, 1'b1};  // LS
    vecs[12] = '{4'b1001, 4'b1010, 1'b1};  // GE, N=V=1
    vecs[13] = '{4'b1000, 4'b1011, 1'b1};  // LT, N!=V
    vecs[14] = '{4'b0000, 4'b1100, 1'b1};  // GT
    vecs[15] = '{4'b0100, 4'b1100, 1'b0};  // GT, Z=1
    vecs[16] = '{4'b1000, 4'b1101, 1'b1};  // LE, N!=V
    vecs[17] = '{4'b0000, 4'b1110, 1'b1};  // AL
    vecs[18] = '{4'b1111, 4'b1111, 1'b0};  // NV

    reset = 1'b1; CondSample = 1'b1; InstrDone = 1'b0; ITStart = 1'b0;
    PCS = 1'b1; NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1;
    Cond = 4'b1110; ALUFlags = 4'b1111; ITCond = 4'b0000; ITMask = 4'b0000;
    ITLen = 2'd0; FlagW = 2'b11; FlagW4 = 4'b0000;

    // Reset: gated writes are off, PCWrite follows NextPC.
    step();
    check("rst_regwrite", a_rw, 1'b0);
    check("rst_memwrite", a_mw, 1'b0);
    check("rst_pcwrite_nextpc1", a_pcw, 1'b1);
    NextPC = 1'b0; #1;
    check("rst_pcwrite_nextpc0", a_pcw, 1'b0);
    step();
    check("rst_flags", a_flags, 4'b0000);
    check("rst_condexr", a_cer, 1'b0);
    check("rst_itactive", a_ita, 1'b0);
    reset = 1'b0;

    // EQ right after reset: Z=0, so nothing is enabled and no flags load.
    Cond = 4'b0000; CondSample = 1'b1; FlagW = 2'b11; ALUFlags = 4'b1111;
    RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; NextPC = 1'b0;
    step();
    check("eq_z0_condexr", a_cer, 1'b0);
    check("eq_z0_regwrite", a_rw, 1'b0);
    check("eq_z0_memwrite", a_mw, 1'b0);
    check("eq_z0_pcwrite_pcs", a_pcw, 1'b0);
    check("eq_z0_d0_flags", c_flags, 4'b0000);
    NextPC = 1'b1; #1;
    check("eq_z0_pcwrite_nextpc", a_pcw, 1'b1);
    // FlagW outside CondSample is ignored.
    CondSample = 1'b0; NextPC = 1'b0;
    step(); step();
    check("eq_z0_flags_hold", a_flags, 4'b0000);
    check("flagw_no_sample", c_flags, 4'b0000);
    FlagW = 2'b00; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

    // Condition table: load flags through the AL path, then sample the row's condition.
    prev = 4'b0000;
    for (int i = 0; i < 19; i++) begin
      ALUFlags = vecs[i].flags; Cond = 4'b1110; CondSample = 1'b1; FlagW = 2'b11;
      step();
      check($sformatf("vec%0d_delay_hold", i), a_flags, prev);
      check($sformatf("vec%0d_d0_flags", i), c_flags, vecs[i].flags);
      CondSample = 1'b0; FlagW = 2'b00;
      step();
      check($sformatf("vec%0d_flags", i), a_flags, vecs[i].flags);
      Cond = vecs[i].cond; CondSample = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
      step();
      check($sformatf("vec%0d_condexr", i), a_cer, vecs[i].exp);
      check($sformatf("vec%0d_regwrite", i), a_rw, vecs[i].exp);
      check($sformatf("vec%0d_memwrite", i), a_mw, vecs[i].exp);
      check($sformatf("vec%0d_pcwrite", i), a_pcw, vecs[i].exp);
      CondSample = 1'b0; RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;
      prev = vecs[i].flags;
    end

    // Group write: FlagW=10 updates only N,Z (flags were 1111).
    ALUFlags = 4'b0000; Cond = 4'b1110; CondSample = 1'b1; FlagW = 2'b10;
    step();
    check("grp_nz_d0", c_flags, 4'b0011);
    CondSample = 1'b0; FlagW = 2'b00;
    step();
    check("grp_nz_d1", a_flags, 4'b0011);

    // Sample coinciding with a delayed flag write: evaluation sees old Z=0.
    ALUFlags = 4'b0100; Cond = 4'b1110; CondSample = 1'b1; FlagW = 2'b11;
    step();
    Cond = 4'b0000; FlagW = 2'b00;
    step();
    check("overlap_condexr_old", a_cer, 1'b0);
    check("overlap_flags_new", a_flags, 4'b0100);
    step();
    check("overlap_next_eq", a_cer, 1'b1);
    CondSample = 1'b0;

    // Four groups, delay 2: only flag bit 1 loads, two cycles after the sample.
    ALUFlags = 4'b1111; Cond = 4'b1110; CondSample = 1'b1; FlagW4 = 4'b0010;
    step();
    CondSample = 1'b0; FlagW4 = 4'b0000;
    step();
    check("g4_d2_hold", b_flags, 4'b0000);
    step();
    check("g4_d2_load", b_flags, 4'b0010);
    check("g4_other_dut_hold", a_flags, 4'b0100);

`ifdef COND_IT_EN
    // IT block EQ, len 3, mask 0101 with Z=1: then/else/then -> 1,0,1.
    it_exp[0] = 1'b1; it_exp[1] = 1'b0; it_exp[2] = 1'b1;
    ITStart = 1'b1; ITCond = 4'b0000; ITLen = 2'd2; ITMask = 4'b0101;
    step();
    ITStart = 1'b0;
    check("it_start_active", a_ita, 1'b1);
    for (int k = 0; k < 3; k++) begin
      Cond = 4'b1111; CondSample = 1'b1;
      step();
      check($sformatf("it_slot%0d_condexr", k), a_cer, it_exp[k]);
      CondSample = 1'b0;
      step();
      check($sformatf("it_slot%0d_stall_active", k), a_ita, 1'b1);
      InstrDone = 1'b1;
      step();
      InstrDone = 1'b0;
      check($sformatf("it_slot%0d_after_done", k), a_ita, (k < 2) ? 1'b1 : 1'b0);
    end
    Cond = 4'b0000; CondSample = 1'b1;
    step();
    check("it_after_uses_cond", a_cer, 1'b1);
    CondSample = 1'b0;

    // ITStart with InstrDone in the same cycle: the start wins.
    ITStart = 1'b1; InstrDone = 1'b1; ITLen = 2'd0; ITMask = 4'b0001;
    step();
    ITStart = 1'b0;
    check("it_start_wins", a_ita, 1'b1);
    step();
    InstrDone = 1'b0;
    check("it_len1_done", a_ita, 1'b0);

    // Reset during slot 1 of a 4-long block.
    ITStart = 1'b1; ITLen = 2'd3; ITMask = 4'b1111;
    step();
    ITStart = 1'b0; InstrDone = 1'b1;
    step();
    InstrDone = 1'b0;
    check("it_mid_block_active", a_ita, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("it_reset_active", a_ita, 1'b0);
    check("it_reset_flags_a", a_flags, 4'b0000);
    check("it_reset_flags_b", b_flags, 4'b0000);
    check("it_reset_flags_c", c_flags, 4'b0000);
    Cond = 4'b0001; CondSample = 1'b1;
    step();
    check("it_reset_uses_cond", a_cer, 1'b1);
    CondSample = 1'b0;
`else
    // Without predication the IT inputs have no effect.
    it_exp[0] = 1'b0; it_exp[1] = 1'b0; it_exp[2] = 1'b0;
    ITStart = 1'b1; ITCond = 4'b0001; ITLen = 2'd3; ITMask = 4'b1111; InstrDone = 1'b1;
    Cond = 4'b0000; CondSample = 1'b1;
    step();
    check("noit_active", a_ita, 1'b0);
    check("noit_uses_cond", a_cer, 1'b1);
    ITStart = 1'b0; InstrDone = 1'b0; CondSample = 1'b0;
    check("noit_unused_exp", {3'b000, it_exp[0]}, {3'b000, a_ita});
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("noit_reset_flags", a_flags, 4'b0000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
